instr_word_encoder: RTL and testbench

Encodes ALU-level operation requests (4-bit ALU operation code plus register/immediate fields) into 32-bit RV32I instruction words. Buffers them in a small FIFO and streams them, each with a word address, to the instruction-memory loader over a valid/ready handshake. It is the inverse of the ALU control decoder: it uses the same 4-bit operation code space and lets testbenches and the boot loader generate programs the core decodes back to the same ALU operations.

---
 rtl/riscv_isa_pkg.sv | 86 ++++++++
 rtl/instr_enc_fifo.sv | 71 +++++++
 rtl/instr_word_encoder.sv | 202 ++++++++++++++++++++
 tb/tb_instr_word_encoder.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_isa_pkg.sv
// RV32I encoding constants shared by the instruction encoder and the ALU
// control decoder, plus the field-assembly helper for each instruction format.
package riscv_isa_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // funct3 values
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // 4-bit ALU operation codes
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_OR_LUI = 4'b0001;
    localparam logic [3:0] ALU_ORI    = 4'b0010;
    localparam logic [3:0] ALU_SLL    = 4'b0011;
    localparam logic [3:0] ALU_SRL    = 4'b0100;
    localparam logic [3:0] ALU_SUB    = 4'b0101;
    localparam logic [3:0] ALU_AND    = 4'b0110;
    localparam logic [3:0] ALU_XOR    = 4'b0111;
    localparam logic [3:0] ALU_BEQ    = 4'b1000;
    localparam logic [3:0] ALU_BNE    = 4'b1001;
    localparam logic [3:0] ALU_BGE    = 4'b1010;
    localparam logic [3:0] ALU_BLT    = 4'b1011;
    localparam logic [3:0] ALU_JAL    = 4'b1100;
    localparam logic [3:0] ALU_JALR   = 4'b1101;
    localparam logic [3:0] ALU_LW     = 4'b1110;
    localparam logic [3:0] ALU_SW     = 4'b1111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    // Place fields according to the format; fields a format lacks encode as 0.
    function automatic logic [31:0] assemble_word(
        input imm_fmt_e    fmt,
        input logic [6:0]  opc,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [20:0] imm
    );
        logic [31:0] w;
        w = '0;
        case (fmt)
            FMT_R: w = {f7, rs2, rs1, f3, rd, opc};
            FMT_I: w = {imm[11:0], rs1, f3, rd, opc};
            FMT_S: w = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
            FMT_B: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
            FMT_U: w = {imm[19:0], rd, opc};
            FMT_J: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Synchronous DEPTH-entry FIFO holding {instruction word, word address}.
// Read data is combinational from the head entry and reads as 0 when empty.
module instr_enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned    PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

    // Next pointer and storage state: flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q[PTR_W-1:0]] = data_i;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Pointer registers; async reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are never visible while empty, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instr_word_encoder.sv
// Encodes 4-bit ALU operation requests into RV32I words, buffers them with
// a running word address, and streams them out over valid/ready.
module instr_word_encoder
    import riscv_isa_pkg::*;
#(
    parameter int unsigned          DEPTH     = 4,
    parameter int unsigned          ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [3:0]        alu_op_i,
    input  logic              imm_sel_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [20:0]       imm_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] instr_addr_o,
    output logic              err_o,
    output logic [7:0]        err_cnt_o
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    imm_fmt_e          fmt;
    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [20:0]       imm_eff;
    logic              illegal;
    logic [31:0]       enc_word;

    logic              fifo_full;
    logic              fifo_empty;
    logic [31+ADDR_W:0] fifo_rdata;
    logic              accept;
    logic              push;
    logic              pop;

    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    // Map the ALU operation code to format, opcode and function fields.
    always_comb begin
        fmt     = FMT_R;
        opc     = OPC_OP;
        f3      = F3_ADD;
        f7      = F7_BASE;
        imm_eff = imm_i;
        illegal = 1'b0;
        case (alu_op_i)
            ALU_ADD: begin
                f3 = F3_ADD;
                if (imm_sel_i) begin
                    fmt = FMT_I;
                    opc = OPC_OP_IMM;
                end
            end
            ALU_OR_LUI: begin
                if (imm_sel_i) begin
                    fmt = FMT_U;
                    opc = OPC_LUI;
                end else begin
                    f3 = F3_OR;
                end
            end
            ALU_ORI: begin
                fmt = FMT_I;
                opc = OPC_OP_IMM;
                f3  = F3_OR;
            end
            ALU_SLL, ALU_SRL: begin
                f3 = (alu_op_i == ALU_SLL) ? F3_SLL : F3_SRL;
                if (imm_sel_i) begin
                    // Shift-immediate: upper immediate bits are zero, shamt in [4:0].
                    fmt     = FMT_I;
                    opc     = OPC_OP_IMM;
                    imm_eff = {16'd0, imm_i[4:0]};
                end
            end
            ALU_SUB: begin
                f3      = F3_ADD;
                f7      = F7_ALT;
                illegal = imm_sel_i;
            end
            ALU_AND: begin
                f3 = F3_AND;
                if (imm_sel_i) begin
                    fmt = FMT_I;
                    opc = OPC_OP_IMM;
                end
            end
            ALU_XOR: begin
                f3 = F3_XOR;
                if (imm_sel_i) begin
                    fmt = FMT_I;
                    opc = OPC_OP_IMM;
                end
            end
            ALU_BEQ, ALU_BNE, ALU_BGE, ALU_BLT: begin
                fmt     = FMT_B;
                opc     = OPC_BRANCH;
                illegal = imm_i[0];
                case (alu_op_i)
                    ALU_BEQ: f3 = F3_BEQ;
                    ALU_BNE: f3 = F3_BNE;
                    ALU_BGE: f3 = F3_BGE;
                    default: f3 = F3_BLT;
                endcase
            end
            ALU_JAL: begin
                fmt     = FMT_J;
                opc     = OPC_JAL;
                illegal = imm_i[0];
            end
            ALU_JALR: begin
                fmt = FMT_I;
                opc = OPC_JALR;
                f3  = F3_JALR;
            end
            ALU_LW: begin
                fmt = FMT_I;
                opc = OPC_LOAD;
                f3  = F3_LW;
            end
            ALU_SW: begin
                fmt = FMT_S;
                opc = OPC_STORE;
                f3  = F3_SW;
            end
            default: begin
                fmt = FMT_R;
            end
        endcase
        enc_word = assemble_word(fmt, opc, f3, f7, rd_i, rs1_i, rs2_i, imm_eff);
    end

    // Flush blocks requests so nothing is accepted into a FIFO being cleared.
    assign op_ready_o    = !fifo_full && !flush_i;
    assign accept        = op_valid_i && op_ready_o;
    assign push          = accept && !illegal;
    assign instr_valid_o = !fifo_empty;
    assign pop           = instr_valid_o && instr_ready_i;
    assign {instr_o, instr_addr_o} = fifo_rdata;

    instr_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32 + ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  ({enc_word, addr_cnt_q}),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Address counter advances only on legal pushes; error count saturates.
    always_comb begin
        addr_cnt_d = addr_cnt_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        if (flush_i) begin
            addr_cnt_d = BASE_ADDR;
        end else if (push) begin
            addr_cnt_d = addr_cnt_q + ADDR_ONE;
        end
        if (accept && illegal) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // Counter and error-pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_cnt_q <= BASE_ADDR;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            addr_cnt_q <= addr_cnt_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_instr_word_encoder.sv
// Bench for instr_word_encoder: two instances (8-bit and 2-bit address) share
// stimulus and are compared every cycle against a queue-based reference model.
module tb_instr_word_encoder;

    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0]  op;
        logic        sel;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [20:0] imm;
    } req_t;

    typedef struct {
        logic [31:0] w;
        int unsigned a;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        op_valid_i;
    logic [3:0]  alu_op_i;
    logic        imm_sel_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [20:0] imm_i;
    logic        instr_ready_i;

    logic        a_ready, a_valid, a_err;
    logic [31:0] a_instr;
    logic [7:0]  a_addr, a_cnt;
    logic        b_ready, b_valid, b_err;
    logic [31:0] b_instr;
    logic [1:0]  b_addr;
    logic [7:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    req_t        pend[$];
    ent_t        exp_q[$];
    int unsigned m_addr = 0;
    int unsigned m_cnt  = 0;
    bit          m_err  = 0;

    localparam logic [95:0] RST_VEC = {1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 8'h00,
                                       1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00};

    always #5 clk = ~clk;

    instr_word_encoder #(.DEPTH(DEPTH), .ADDR_W(8)) u_dut (
        .clk(clk), .reset(rst_n), .flush_i(flush_i),
        .op_valid_i(op_valid_i), .op_ready_o(a_ready),
        .alu_op_i(alu_op_i), .imm_sel_i(imm_sel_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .instr_valid_o(a_valid), .instr_ready_i(instr_ready_i),
        .instr_o(a_instr), .instr_addr_o(a_addr),
        .err_o(a_err), .err_cnt_o(a_cnt)
    );

    instr_word_encoder #(.DEPTH(DEPTH), .ADDR_W(2)) u_dut_w2 (
        .clk(clk), .reset(rst_n), .flush_i(flush_i),
        .op_valid_i(op_valid_i), .op_ready_o(b_ready),
        .alu_op_i(alu_op_i), .imm_sel_i(imm_sel_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .instr_valid_o(b_valid), .instr_ready_i(instr_ready_i),
        .instr_o(b_instr), .instr_addr_o(b_addr),
        .err_o(b_err), .err_cnt_o(b_cnt)
    );

    // ---------------- reference encoder (plain arithmetic) ----------------
    function automatic int unsigned rtype(int unsigned f7, int unsigned f3,
                                          int unsigned rd, int unsigned rs1, int unsigned rs2);
        return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
    endfunction

    function automatic int unsigned itype(int unsigned imm12, int unsigned f3,
                                          int unsigned rd, int unsigned rs1, int unsigned opc);
        return (imm12 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
    endfunction

    function automatic logic [32:0] ref_encode(req_t r);
        int unsigned rd  = r.rd;
        int unsigned rs1 = r.rs1;
        int unsigned rs2 = r.rs2;
        int unsigned imm = r.imm;
        int unsigned lo  = imm & 'hFFF;
        int unsigned bf3;
        int unsigned w   = 0;
        bit          bad = 0;
        case (r.op)
            4'd0:  w = r.sel ? itype(lo, 0, rd, rs1, 'h13) : rtype(0, 0, rd, rs1, rs2);
            4'd1:  w = r.sel ? (((imm & 'hFFFFF) << 12) | (rd << 7) | 'h37) : rtype(0, 6, rd, rs1, rs2);
            4'd2:  w = itype(lo, 6, rd, rs1, 'h13);
            4'd3:  w = r.sel ? itype(imm & 31, 1, rd, rs1, 'h13) : rtype(0, 1, rd, rs1, rs2);
            4'd4:  w = r.sel ? itype(imm & 31, 5, rd, rs1, 'h13) : rtype(0, 5, rd, rs1, rs2);
            4'd5:  begin w = rtype(32, 0, rd, rs1, rs2); bad = r.sel; end
            4'd6:  w = r.sel ? itype(lo, 7, rd, rs1, 'h13) : rtype(0, 7, rd, rs1, rs2);
            4'd7:  w = r.sel ? itype(lo, 4, rd, rs1, 'h13) : rtype(0, 4, rd, rs1, rs2);
            4'd8, 4'd9, 4'd10, 4'd11: begin
                bf3 = (r.op == 8) ? 0 : (r.op == 9) ? 1 : (r.op == 10) ? 5 : 4;
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20) |
                    (rs1 << 15) | (bf3 << 12) | (((imm >> 1) & 'hF) << 8) |
                    (((imm >> 11) & 1) << 7) | 'h63;
                bad = imm[0];
            end
            4'd12: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21) |
                    (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
                bad = imm[0];
            end
            4'd13: w = itype(lo, 0, rd, rs1, 'h67);
            4'd14: w = itype(lo, 2, rd, rs1, 'h03);
            default: w = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) |
                         (2 << 12) | ((imm & 31) << 7) | 'h23;
        endcase
        return {bad, w};
    endfunction

    function automatic req_t mk(int op, int sel, int rd, int rs1, int rs2, int imm);
        req_t r;
        r.op = 4'(op); r.sel = 1'(sel); r.rd = 5'(rd); r.rs1 = 5'(rs1);
        r.rs2 = 5'(rs2); r.imm = 21'(imm);
        return r;
    endfunction

    function automatic req_t rand_req(bit legal);
        req_t r;
        r.op  = 4'($urandom_range(0, 15));
        r.sel = 1'($urandom_range(0, 1));
        r.rd  = 5'($urandom);
        r.rs1 = 5'($urandom);
        r.rs2 = 5'($urandom);
        r.imm = 21'($urandom);
        if (legal) begin
            if (r.op == 4'd5) r.sel = 1'b0;
            if (r.op >= 4'd8 && r.op <= 4'd12) r.imm[0] = 1'b0;
        end
        return r;
    endfunction

    // Expected output vector of both instances from the model.
    function automatic logic [95:0] expv();
        logic        er, ev;
        logic [31:0] w;
        logic [7:0]  a;
        er = (exp_q.size() < DEPTH) && !flush_i;
        ev = exp_q.size() != 0;
        w = '0;
        a = '0;
        if (ev) begin
            w = exp_q[0].w;
            a = 8'(exp_q[0].a);
        end
        return {er, ev, m_err, 8'(m_cnt), w, a, er, ev, m_err, 8'(m_cnt), w, a[1:0]};
    endfunction

    // Observed outputs; word/address are masked while not valid when mask=1.
    function automatic logic [95:0] obs(bit mask);
        return {a_ready, a_valid, a_err, a_cnt,
                (mask && !a_valid) ? 32'h0 : a_instr, (mask && !a_valid) ? 8'h0 : a_addr,
                b_ready, b_valid, b_err, b_cnt,
                (mask && !b_valid) ? 32'h0 : b_instr, (mask && !b_valid) ? 2'b0 : b_addr};
    endfunction

    task automatic drive_head();
        if (pend.size() > 0) begin
            op_valid_i = 1'b1;
            alu_op_i   = pend[0].op;
            imm_sel_i  = pend[0].sel;
            rd_i       = pend[0].rd;
            rs1_i      = pend[0].rs1;
            rs2_i      = pend[0].rs2;
            imm_i      = pend[0].imm;
        end else begin
            op_valid_i = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend.delete();
        m_addr = 0;
        m_cnt  = 0;
        m_err  = 0;
    endtask

    // Advance the model by one clock using the handshake rules, then the DUT.
    task automatic tick();
        bit          er, ev;
        logic [32:0] r;
        er = (exp_q.size() < DEPTH) && !flush_i;
        ev = exp_q.size() != 0;
        m_err = 0;
        if (flush_i) begin
            exp_q.delete();
            m_addr = 0;
        end else begin
            if (ev && instr_ready_i) void'(exp_q.pop_front());
            if (pend.size() > 0 && er) begin
                r = ref_encode(pend[0]);
                void'(pend.pop_front());
                if (r[32]) begin
                    m_err = 1;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    exp_q.push_back('{w: r[31:0], a: m_addr});
                    m_addr = (m_addr + 1) % 256;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        drive_head();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        checks++;
        if (obs(1'b0) !== RST_VEC) begin
            errors++;
            $display("FAIL reset_values: got %h exp %h", obs(1'b0), RST_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_head();
    endtask

    task automatic test_directed();
        logic [31:0] lit [6];
        int k = 0;
        lit = '{32'h002081B3, 32'hFFF00293, 32'h402081B3, 32'h123450B7, 32'h00208463, 32'h0020A223};
        instr_ready_i = 1'b1;
        pend.push_back(mk(0, 0, 3, 1, 2, 0));
        pend.push_back(mk(0, 1, 5, 0, 9, 'h1FFFFF));
        pend.push_back(mk(5, 0, 3, 1, 2, 0));
        pend.push_back(mk(1, 1, 1, 3, 3, 'h12345));
        pend.push_back(mk(8, 0, 7, 1, 2, 8));
        pend.push_back(mk(15, 0, 7, 1, 2, 4));
        drive_head();
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (obs(1'b1) !== expv()) begin
                errors++;
                $display("FAIL directed cyc %0d: got %h exp %h", i, obs(1'b1), expv());
            end
            if (a_valid === 1'b1 && k < 6) begin
                checks++;
                if (a_instr !== lit[k] || a_addr !== 8'(k)) begin
                    errors++;
                    $display("FAIL directed_word %0d: got %h@%0d exp %h@%0d", k, a_instr, a_addr, lit[k], k);
                end
                k++;
            end
            tick();
        end
        checks++;
        if (k != 6) begin
            errors++;
            $display("FAIL directed_count: got %0d exp 6", k);
        end
    endtask

    task automatic test_full();
        bit done = 0;
        instr_ready_i = 1'b0;
        repeat (6) pend.push_back(rand_req(1'b1));
        drive_head();
        for (int i = 0; i < 40 && !done; i++) begin
            if (i == 10) instr_ready_i = 1'b1;
            #1;
            checks++;
            if (obs(1'b1) !== expv()) begin
                errors++;
                $display("FAIL full cyc %0d: got %h exp %h", i, obs(1'b1), expv());
            end
            if (i == 5) begin
                checks++;
                if (a_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_ready_low: got %b exp 0", a_ready);
                end
            end
            tick();
            done = (pend.size() == 0) && (exp_q.size() == 0);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL full_drain_timeout: got pend=%0d q=%0d exp 0", pend.size(), exp_q.size());
        end
    endtask

    task automatic test_errors();
        instr_ready_i = 1'b1;
        pend.push_back(mk(5, 1, 3, 1, 2, 12));
        pend.push_back(mk(9, 0, 0, 1, 2, 3));
        pend.push_back(mk(12, 0, 4, 0, 0, 'h801));
        pend.push_back(mk(0, 0, 3, 1, 2, 0));
        drive_head();
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (obs(1'b1) !== expv()) begin
                errors++;
                $display("FAIL errors cyc %0d: got %h exp %h", i, obs(1'b1), expv());
            end
            tick();
        end
    endtask

    task automatic test_wrap_flush();
        instr_ready_i = 1'b1;
        flush_i = 1'b1;
        drive_head();
        #1;
        checks++;
        if (obs(1'b1) !== expv()) begin
            errors++;
            $display("FAIL flush_start: got %h exp %h", obs(1'b1), expv());
        end
        tick();
        flush_i = 1'b0;
        repeat (5) pend.push_back(rand_req(1'b1));
        drive_head();
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++;
            if (obs(1'b1) !== expv()) begin
                errors++;
                $display("FAIL wrap cyc %0d: got %h exp %h", i, obs(1'b1), expv());
            end
            tick();
        end
        instr_ready_i = 1'b0;
        repeat (3) pend.push_back(rand_req(1'b1));
        drive_head();
        for (int i = 0; i < 6; i++) begin
            flush_i = (i == 2);
            #1;
            checks++;
            if (obs(1'b1) !== expv()) begin
                errors++;
                $display("FAIL flush cyc %0d: got %h exp %h", i, obs(1'b1), expv());
            end
            if (i == 4) instr_ready_i = 1'b1;
            tick();
        end
        flush_i = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (pend.size() == 0 && $urandom_range(0, 9) < 7)
                pend.push_back(rand_req($urandom_range(0, 3) != 0));
            instr_ready_i = ($urandom_range(0, 9) < 7);
            flush_i = ($urandom_range(0, 49) == 0);
            drive_head();
            #1;
            checks++;
            if (obs(1'b1) !== expv()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h exp %h", i, obs(1'b1), expv());
            end
            tick();
        end
        flush_i = 1'b0;
    endtask

    task automatic test_err_saturate();
        instr_ready_i = 1'b1;
        repeat (260) pend.push_back(mk(5, 1, $urandom, $urandom, $urandom, $urandom));
        drive_head();
        for (int i = 0; i < 300 && (pend.size() != 0 || exp_q.size() != 0); i++) begin
            #1;
            checks++;
            if (obs(1'b1) !== expv()) begin
                errors++;
                $display("FAIL saturate cyc %0d: got %h exp %h", i, obs(1'b1), expv());
            end
            tick();
        end
        #1;
        checks++;
        if (a_cnt !== 8'hFF || b_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL err_cnt_saturate: got %h/%h exp ff", a_cnt, b_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        instr_ready_i = 1'b0;
        repeat (3) pend.push_back(rand_req(1'b1));
        drive_head();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (obs(1'b1) !== expv()) begin
                errors++;
                $display("FAIL prefill cyc %0d: got %h exp %h", i, obs(1'b1), expv());
            end
            tick();
        end
        pend.push_back(rand_req(1'b1));
        drive_head();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs(1'b0) !== RST_VEC) begin
            errors++;
            $display("FAIL async_reset: got %h exp %h", obs(1'b0), RST_VEC);
        end
        model_reset();
        drive_head();
        @(negedge clk);
        rst_n = 1'b1;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (obs(1'b1) !== expv()) begin
                errors++;
                $display("FAIL post_reset cyc %0d: got %h exp %h", i, obs(1'b1), expv());
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        flush_i = 1'b0;
        op_valid_i = 1'b0;
        alu_op_i = '0;
        imm_sel_i = 1'b0;
        rd_i = '0;
        rs1_i = '0;
        rs2_i = '0;
        imm_i = '0;
        instr_ready_i = 1'b0;
        test_reset();
        test_directed();
        test_full();
        test_errors();
        test_wrap_flush();
        test_random();
        test_err_saturate();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

endmodule
